// File: rtl/avmm_burst_reader_if.sv
// Avalon-MM read master bundle for avmm_burst_reader: request, burst and read-data return signals.
interface avmm_burst_reader_if #(
   parameter int DATA_W  = 512,
   parameter int ADDR_W  = 64,
   parameter int BURST_W = 3
);
   logic                  m_waitrequest;
   logic [DATA_W-1:0]     m_readdata;
   logic                  m_readdatavalid;
   logic [ADDR_W-1:0]     m_address;
   logic                  m_read;
   logic [BURST_W-1:0]    m_burstcount;
   logic [DATA_W/8-1:0]   m_byteenable;

   modport master (
      input  m_waitrequest, m_readdata, m_readdatavalid,
      output m_address, m_read, m_burstcount, m_byteenable
   );

   modport slave (
      output m_waitrequest, m_readdata, m_readdatavalid,
      input  m_address, m_read, m_burstcount, m_byteenable
   );
endinterface

// File: rtl/avmm_burst_reader.sv
// Credit-limited Avalon-MM burst read engine forwarding returned beats as a registered stream.
// Optional waitrequest stall counter is built only when AVMM_RD_PERF_EN is defined.
module avmm_burst_reader #(
   parameter int DATA_W  = 512,
   parameter int ADDR_W  = 64,
   parameter int BURST_W = 3,
   parameter int CREDITS = 256,
   parameter int CNT_W   = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [CNT_W-1:0]    beat_count,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [CNT_W-1:0]    issued_beats,
   output logic [CNT_W-1:0]    recv_beats,
   output logic [31:0]         stall_cycles,
   avmm_burst_reader_if.master avm,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_pop
);
   localparam int MAX_BURST = 2 ** (BURST_W - 1);
   localparam int BYTE_SH   = $clog2(DATA_W / 8);
   localparam int CRED_W    = $clog2(CREDITS + 1);
   localparam int LEN_W     = (CRED_W > BURST_W) ? CRED_W : BURST_W;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   base_addr;
   logic [CNT_W-1:0]    xfer_len;
   logic [CNT_W-1:0]    remaining;
   logic [BURST_W-1:0]  len;
   logic [CRED_W-1:0]   credits;
   logic                rd_armed;
   logic                abort_seen;
   logic                slot_free;
   logic                issue_go;
   logic                beat_in;

   assign busy             = (state == ISSUE) || (state == DRAIN);
   assign done             = (state == DONE);
   assign avm.m_byteenable = '1;
   // Beats still in flight from before a reset are dropped until the next start re-arms.
   assign beat_in          = avm.m_readdatavalid & rd_armed;

   always_comb begin
      state_nxt  = state;
      issue_go   = 1'b0;
      remaining  = xfer_len - issued_beats;
      len        = (remaining >= CNT_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                    : remaining[BURST_W-1:0];
      abort_seen = aborted | (abort & (state == ISSUE));
      slot_free  = ~avm.m_read | ~avm.m_waitrequest;
      case (state)
         IDLE:  if (start) state_nxt = ISSUE;
         ISSUE: begin
            if (slot_free && !abort_seen && (remaining != '0) &&
                (LEN_W'(credits) >= LEN_W'(len)))
               issue_go = 1'b1;
            else if (slot_free && ((remaining == '0) || abort_seen))
               state_nxt = DRAIN;
         end
         DRAIN: if (recv_beats == issued_beats) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         base_addr        <= '0;
         xfer_len         <= '0;
         issued_beats     <= '0;
         recv_beats       <= '0;
         credits          <= CRED_W'(CREDITS);
         aborted          <= 1'b0;
         rd_armed         <= 1'b0;
         avm.m_read       <= 1'b0;
         avm.m_address    <= '0;
         avm.m_burstcount <= BURST_W'(1);
         out_valid        <= 1'b0;
         out_data         <= '0;
      end else begin
         state <= state_nxt;

         if ((state == IDLE) && start) begin
            base_addr    <= src_addr;
            xfer_len     <= beat_count;
            issued_beats <= '0;
            recv_beats   <= '0;
            aborted      <= 1'b0;
            rd_armed     <= 1'b1;
         end else begin
            if (abort && ((state == ISSUE) || (state == DRAIN)))
               aborted <= 1'b1;
            if (beat_in)
               recv_beats <= recv_beats + CNT_W'(1);
            if (issue_go)
               issued_beats <= issued_beats + CNT_W'(len);
         end

         // Request outputs only move when the bus is free; a stalled request holds.
         if (issue_go) begin
            avm.m_read       <= 1'b1;
            avm.m_burstcount <= len;
            avm.m_address    <= base_addr + (ADDR_W'(issued_beats) << BYTE_SH);
         end else if (!avm.m_waitrequest) begin
            avm.m_read <= 1'b0;
         end

         // Credits are spent at issue and returned per pop, never above the FIFO depth.
         credits <= credits
                    - (issue_go ? CRED_W'(len) : '0)
                    + ((out_pop && (credits != CRED_W'(CREDITS))) ? CRED_W'(1) : '0);

         out_valid <= beat_in;
         if (beat_in)
            out_data <= avm.m_readdata;
      end
   end

`ifdef AVMM_RD_PERF_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_cycles <= '0;
      else if ((state == IDLE) && start)
         stall_cycles <= '0;
      else if (avm.m_read && avm.m_waitrequest && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 32'd1;
   end
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_avmm_burst_reader.sv
// Scoreboard bench for avmm_burst_reader: Avalon slave model, downstream FIFO model and burst planner.
module tb_avmm_burst_reader;
   localparam int DATA_W    = 512;
   localparam int ADDR_W    = 64;
   localparam int BURST_W   = 3;
   localparam int CREDITS   = 8;
   localparam int CNT_W     = 64;
   localparam int MAX_BURST = 4;
   localparam int STRIDE    = DATA_W / 8;
`ifdef AVMM_RD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      logic [ADDR_W-1:0] a;
      int                len;
   } burst_t;
   typedef struct {
      int                t;
      logic [DATA_W-1:0] d;
   } beat_t;

   logic              clk;
   logic              reset;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] src_addr;
   logic [CNT_W-1:0]  beat_count;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [CNT_W-1:0]  issued_beats;
   logic [CNT_W-1:0]  recv_beats;
   logic [31:0]       stall_cycles;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_pop;

   avmm_burst_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) avm ();

   avmm_burst_reader #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .CREDITS(CREDITS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .src_addr(src_addr), .beat_count(beat_count),
      .busy(busy), .done(done), .aborted(aborted),
      .issued_beats(issued_beats), .recv_beats(recv_beats), .stall_cycles(stall_cycles),
      .avm(avm), .out_data(out_data), .out_valid(out_valid), .out_pop(out_pop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   burst_t            exp_burst[$];
   logic [DATA_W-1:0] exp_data[$];
   beat_t             ret_q[$];

   int  cyc        = 0;
   int  lat        = 2;
   bit  rand_wait  = 1'b0;
   bit  rand_gap   = 1'b0;
   bit  pop_en     = 1'b1;
   bit  drop_mode  = 1'b0;
   int  hold_cnt   = 0;
   int  extra_pops = 0;
   int  fifo_lvl   = 0;
   int  pops       = 0;
   int  acc_beats  = 0;
   int  acc_cnt    = 0;
   int  stall_tb   = 0;
   bit  hold_prev  = 1'b0;
   logic [ADDR_W-1:0]  prev_addr;
   logic [BURST_W-1:0] prev_bc;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Avalon slave, stream monitor and downstream FIFO model, all on the falling edge.
   always @(negedge clk) begin
      logic              wr;
      burst_t            b;
      logic [DATA_W-1:0] d;
      cyc++;

      if (out_valid) begin
         total++;
         if (exp_data.size() == 0) begin
            bad++;
            $display("FAIL stray_beat: got out_valid=1 data %0h, required no beat", out_data[63:0]);
         end else begin
            d = exp_data.pop_front();
            if (out_data !== d) begin
               bad++;
               $display("FAIL beat_data: got %0h, required %0h", out_data[63:0], d[63:0]);
            end
            fifo_lvl++;
         end
      end

      if (hold_prev) begin
         chk("hold_read", 64'(avm.m_read), 64'd1);
         chk("hold_addr", avm.m_address, prev_addr);
         chk("hold_burstcount", 64'(avm.m_burstcount), 64'(prev_bc));
      end

      wr = 1'b0;
      if (avm.m_read && hold_cnt > 0) begin
         wr = 1'b1;
         hold_cnt--;
      end else if (rand_wait && $urandom_range(0, 2) == 0) begin
         wr = 1'b1;
      end
      avm.m_waitrequest = wr;
      hold_prev = !reset && avm.m_read && wr;
      prev_addr = avm.m_address;
      prev_bc   = avm.m_burstcount;
      if (hold_prev) stall_tb++;

      if (!reset && avm.m_read && !wr) begin
         acc_cnt++;
         if (exp_burst.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_burst: got addr %0h len %0d, required no burst",
                     avm.m_address, avm.m_burstcount);
         end else begin
            b = exp_burst.pop_front();
            chk("burst_addr", avm.m_address, b.a);
            chk("burst_len", 64'(avm.m_burstcount), 64'(b.len));
         end
         acc_beats += int'(avm.m_burstcount);
         chk("credit_bound", 64'(acc_beats - pops <= CREDITS), 64'd1);
         for (int i = 0; i < int'(avm.m_burstcount); i++)
            ret_q.push_back('{cyc + lat, rand_data()});
      end

      if (ret_q.size() > 0 && ret_q[0].t <= cyc && !(rand_gap && $urandom_range(0, 3) == 0)) begin
         avm.m_readdatavalid = 1'b1;
         avm.m_readdata      = ret_q[0].d;
         if (!drop_mode) exp_data.push_back(ret_q[0].d);
         void'(ret_q.pop_front());
      end else begin
         avm.m_readdatavalid = 1'b0;
         avm.m_readdata      = rand_data();
      end

      if (!reset && extra_pops > 0) begin
         out_pop = 1'b1;
         extra_pops--;
      end else if (!reset && pop_en && fifo_lvl > 0 && $urandom_range(0, 1) == 1) begin
         out_pop = 1'b1;
         fifo_lvl--;
         pops++;
      end else begin
         out_pop = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_start(input logic [ADDR_W-1:0] a, input int n);
      int                rem;
      int                l;
      logic [ADDR_W-1:0] off;
      rem = n;
      off = '0;
      while (rem > 0) begin
         l = (rem > MAX_BURST) ? MAX_BURST : rem;
         exp_burst.push_back('{a + off * STRIDE, l});
         off += ADDR_W'(l);
         rem -= l;
      end
      src_addr   = a;
      beat_count = CNT_W'(n);
      stall_tb   = 0;
      acc_cnt    = 0;
      start      = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic finish_xfer(input int exp_cnt, input bit exp_ab, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk({tag, "_done_seen"}, 64'(ok), 64'd1);
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      chk({tag, "_issued"}, issued_beats, 64'(exp_cnt));
      chk({tag, "_recv"}, recv_beats, 64'(exp_cnt));
      chk({tag, "_aborted"}, 64'(aborted), 64'(exp_ab));
      chk({tag, "_beats_left"}, 64'(exp_data.size()), 64'd0);
      chk({tag, "_stall_cycles"}, 64'(stall_cycles), PERF ? 64'(stall_tb) : 64'd0);
      if (!exp_ab) chk({tag, "_bursts_left"}, 64'(exp_burst.size()), 64'd0);
      step();
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   task automatic drain_fifo();
      for (int i = 0; i < 300 && (fifo_lvl > 0 || ret_q.size() > 0); i++) step();
      repeat (3) step();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_aborted"}, 64'(aborted), 64'd0);
      chk({tag, "_issued"}, issued_beats, 64'd0);
      chk({tag, "_recv"}, recv_beats, 64'd0);
      chk({tag, "_stall"}, 64'(stall_cycles), 64'd0);
      chk({tag, "_m_read"}, 64'(avm.m_read), 64'd0);
      chk({tag, "_m_address"}, avm.m_address, 64'd0);
      chk({tag, "_m_burstcount"}, 64'(avm.m_burstcount), 64'd1);
      chk({tag, "_m_byteenable"}, avm.m_byteenable, 64'hFFFF_FFFF_FFFF_FFFF);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_data"}, out_data[63:0], 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] a;
      int                n;
      bit                seen;

      reset = 1'b1; start = 1'b0; abort = 1'b0; src_addr = '0; beat_count = '0;
      repeat (3) step();
      reset = 1'b0;
      check_reset_vals("rst");

      // Plain 10-beat transfer: bursts 4,4,2 from 0x1000.
      run_start(64'h1000, 10);
      finish_xfer(10, 1'b0, "t1");
      chk("t1_burst_count", 64'(acc_cnt), 64'd3);

      // Pops on a full credit pool are ignored, so only two bursts fit.
      drain_fifo();
      extra_pops = 4;
      repeat (8) step();
      pop_en = 1'b0;
      run_start(64'h4000, 16);
      repeat (40) step();
      chk("t2_stall_issued", issued_beats, 64'd8);
      chk("t2_stall_recv", recv_beats, 64'd8);
      chk("t2_stall_busy", 64'(busy), 64'd1);
      chk("t2_stall_read", 64'(avm.m_read), 64'd0);
      src_addr = 64'h9000; beat_count = 64'd5; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      chk("t2_ignored_start", issued_beats, 64'd8);
      pop_en = 1'b1;
      finish_xfer(16, 1'b0, "t2");

      // Five waitrequest cycles on the first request.
      drain_fifo();
      hold_cnt = 5;
      run_start(64'h2000, 4);
      finish_xfer(4, 1'b0, "t3");
      chk("t3_stall_cycles", 64'(stall_cycles), PERF ? 64'd5 : 64'd0);

      // Abort after the second burst with reads outstanding.
      drain_fifo();
      lat = 8;
      run_start(64'h8000, 16);
      for (int i = 0; i < 100 && acc_cnt < 2; i++) step();
      chk("t4_two_bursts", 64'(acc_cnt), 64'd2);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      finish_xfer(8, 1'b1, "t4");
      chk("t4_no_third_burst", 64'(acc_cnt), 64'd2);
      exp_burst.delete();

      // Zero-length transfer: done three cycles after start, no request.
      drain_fifo();
      lat = 2;
      run_start(64'h3000, 0);
      chk("t5_aborted_cleared", 64'(aborted), 64'd0);
      chk("t5_done_c1", 64'(done), 64'd0);
      step();
      chk("t5_done_c2", 64'(done), 64'd0);
      chk("t5_read_c2", 64'(avm.m_read), 64'd0);
      step();
      chk("t5_done_c3", 64'(done), 64'd1);
      chk("t5_busy_c3", 64'(busy), 64'd0);
      chk("t5_issued", issued_beats, 64'd0);
      step();
      chk("t5_done_pulse", 64'(done), 64'd0);
      chk("t5_no_bursts", 64'(acc_cnt), 64'd0);

      // Reset mid-transfer; late beats must be dropped.
      drain_fifo();
      lat = 4;
      run_start(64'h5000, 12);
      for (int i = 0; i < 100 && acc_cnt < 2; i++) step();
      reset = 1'b1;
      drop_mode = 1'b1;
      step();
      step();
      reset = 1'b0;
      fifo_lvl = 0; pops = 0; acc_beats = 0;
      exp_burst.delete();
      check_reset_vals("t6");
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      chk("t6_no_stray_valid", 64'(seen), 64'd0);
      chk("t6_recv_zero", recv_beats, 64'd0);
      exp_data.delete();
      drop_mode = 1'b0;
      fifo_lvl = 0;
      run_start(64'h6000, 3);
      finish_xfer(3, 1'b0, "t6b");
      chk("t6b_one_burst", 64'(acc_cnt), 64'd1);

      // Randomised transfers with stalls, gaps and random pops.
      rand_wait = 1'b1;
      rand_gap  = 1'b1;
      for (int t = 0; t < 6; t++) begin
         lat = $urandom_range(1, 5);
         a = {$urandom, $urandom};
         a[5:0] = '0;
         n = $urandom_range(1, 20);
         run_start(a, n);
         finish_xfer(n, 1'b0, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
